// File: rtl/grayscale_pkg.sv
// Shared FSM encoding and constants for the sequential RGB565-to-grayscale custom instruction.
package grayscale_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StFlush,
        StDone
    } state_e;

    localparam int unsigned CoefR    = 54;
    localparam int unsigned CoefG    = 183;
    localparam int unsigned CoefB    = 19;
    localparam int unsigned IdxW     = 2;
    localparam int unsigned PixW     = 16;
    localparam int unsigned LaneW    = 8;
    localparam int unsigned NumLanes = 4;
    localparam int unsigned SumW     = 14;

endpackage

// File: rtl/rgb565_to_gray_px.sv
// Single-pixel RGB565 to 8-bit gray: channels widened to 6 bits, weighted sum, top byte kept.
module rgb565_to_gray_px
    import grayscale_pkg::*;
(
    input  logic [PixW-1:0]  pixel_i,
    output logic [LaneW-1:0] gray_o
);

    logic [5:0]      r6;
    logic [5:0]      g6;
    logic [5:0]      b6;
    logic [SumW-1:0] sum;

    // Largest possible sum is 16055, so 14 bits never wrap and no saturation is needed.
    always_comb begin
        r6     = {pixel_i[15:11], 1'b0};
        g6     = pixel_i[10:5];
        b6     = {pixel_i[4:0], 1'b0};
        sum    = SumW'(r6) * SumW'(CoefR) + SumW'(g6) * SumW'(CoefG) + SumW'(b6) * SumW'(CoefB);
        gray_o = sum[SumW-1:6];
    end

endmodule

// File: rtl/grayscale_seq_ci.sv
// Custom instruction converting four RGB565 pixels to packed gray bytes, one pixel per cycle.
// Define GRAYSCALE_SEQ_PIPE_EN to register the converter output (adds a FLUSH cycle).
module grayscale_seq_ci
    import grayscale_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  isId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned ResW = LaneW * NumLanes;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [31:0]         op_a_q, op_a_d;
    logic [31:0]         op_b_q, op_b_d;
    logic [ResW-1:0]     packed_q, packed_d;
    logic                done_q, done_d;
    logic [ResW-1:0]     result_q, result_d;

    logic                trigger;
    logic [63:0]         pixels;
    logic [PixW-1:0]     pixel;
    logic [LaneW-1:0]    gray;

`ifdef GRAYSCALE_SEQ_PIPE_EN
    logic [LaneW-1:0]    gray_q, gray_d;
    logic                wr_en_q, wr_en_d;
    logic [IdxW-1:0]     wr_idx_q, wr_idx_d;
`endif

    assign trigger = start && (isId == customInstructionId);
    assign pixels  = {op_b_q, op_a_q};
    assign pixel   = pixels[int'(idx_q) * PixW +: PixW];

    rgb565_to_gray_px u_px (
        .pixel_i (pixel),
        .gray_o  (gray)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        packed_d = packed_q;
        done_d   = 1'b0;
        result_d = '0;
`ifdef GRAYSCALE_SEQ_PIPE_EN
        // Byte written here belongs to the pixel presented one cycle earlier.
        gray_d   = gray;
        wr_en_d  = (state_q == StConv);
        wr_idx_d = idx_q;
        if (wr_en_q) begin
            packed_d[int'(wr_idx_q) * LaneW +: LaneW] = gray_q;
        end
`endif
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    op_a_d  = valueA;
                    op_b_d  = valueB;
                    idx_d   = '0;
                    state_d = StConv;
                end
            end
            StConv: begin
`ifndef GRAYSCALE_SEQ_PIPE_EN
                packed_d[int'(idx_q) * LaneW +: LaneW] = gray;
`endif
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxW'(NumLanes - 1)) begin
`ifdef GRAYSCALE_SEQ_PIPE_EN
                    state_d = StFlush;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef GRAYSCALE_SEQ_PIPE_EN
            StFlush: begin
                state_d = StDone;
            end
`endif
            StDone: begin
                done_d   = 1'b1;
                result_d = packed_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            packed_q <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef GRAYSCALE_SEQ_PIPE_EN
            gray_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            packed_q <= packed_d;
            done_q   <= done_d;
            result_q <= result_d;
`ifdef GRAYSCALE_SEQ_PIPE_EN
            gray_q   <= gray_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
`endif
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
